// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared state encoding, sizing constants and bit-reversal helper for the FFT sequencer
package fft_seq_pkg;

    localparam int N_PT   = 16;
    localparam int N_STG  = 4;
    localparam int N_BFLY = 8;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE  = 3'd1;
    localparam logic [2:0] DRAIN  = 3'd2;
    localparam logic [2:0] UNLOAD = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    function automatic logic [3:0] bitrev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: maps (stage, butterfly index) to DIF read address pair and twiddle exponent
module fft_addr_gen (
    input  logic [1:0] stage,
    input  logic [2:0] k,
    output logic [3:0] rd_addr_a,
    output logic [3:0] rd_addr_b,
    output logic [2:0] power
);

    logic [3:0] span;
    logic [2:0] mask;

    // span halves every stage; the bit at log2(span) is inserted as 0 so group bits move up one place
    assign span      = 4'd8 >> stage;
    assign mask      = 3'(span - 4'd1);
    assign rd_addr_a = {k & ~mask, 1'b0} | {1'b0, k & mask};
    assign rd_addr_b = rd_addr_a + span;
    assign power     = 3'((k & mask) << stage);

endmodule

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl: sequences one shared radix-2 PE over a 16-point buffer (optional FFT_SEQ_CTRL_UNLOAD_EN adds a bit-reversed unload phase)
module fft_seq_ctrl
    import fft_seq_pkg::*;
#(
    parameter int PE_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [1:0] stage,
    output logic [3:0] rd_addr_a,
    output logic [3:0] rd_addr_b,
    output logic [2:0] power,
    output logic       pe_valid,
`ifdef FFT_SEQ_CTRL_UNLOAD_EN
    output logic       out_valid,
    output logic [3:0] out_bin,
`endif
    output logic       wr_en,
    output logic [3:0] wr_addr_a,
    output logic [3:0] wr_addr_b
);

`ifdef FFT_SEQ_CTRL_UNLOAD_EN
    localparam logic [2:0] LAST = UNLOAD;
`else
    localparam logic [2:0] LAST = DONE;
`endif

    logic [2:0] state;
    logic [1:0] stg;
    logic [3:0] cnt;
    logic       issue;
    logic       unload;
    logic [3:0] ga;
    logic [3:0] gb;
    logic [2:0] gp;
    logic [8:0] pipe [PE_LAT];

    fft_addr_gen u_gen (
        .stage     (stg),
        .k         (cnt[2:0]),
        .rd_addr_a (ga),
        .rd_addr_b (gb),
        .power     (gp)
    );

    assign issue = state == ISSUE;
`ifdef FFT_SEQ_CTRL_UNLOAD_EN
    assign unload    = state == UNLOAD;
    assign out_valid = unload;
    assign out_bin   = unload ? cnt : 4'd0;
`else
    assign unload = 1'b0;
`endif

    assign busy      = issue | state == DRAIN | unload;
    assign done      = state == DONE;
    assign stage     = stg;
    assign pe_valid  = issue & ~abort;
    assign rd_addr_a = issue ? ga : unload ? bitrev4(cnt) : 4'd0;
    assign rd_addr_b = issue ? gb : 4'd0;
    assign power     = issue ? gp : 3'd0;
    assign {wr_en, wr_addr_a, wr_addr_b} = pipe[PE_LAT-1];

    // FSM: cnt is the butterfly index in ISSUE, drain timer in DRAIN, bin index in UNLOAD; stg wraps to 0 after stage 3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            stg   <= 2'd0;
            cnt   <= 4'd0;
        end else if (abort) begin
            state <= IDLE;
            stg   <= 2'd0;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE:  state <= start ? ISSUE : IDLE;
                ISSUE: begin
                    cnt <= cnt == 4'd7 ? 4'd0 : cnt + 4'd1;
                    if (cnt == 4'd7) state <= DRAIN;
                end
                DRAIN: begin
                    if (cnt == 4'(PE_LAT - 1)) begin
                        cnt   <= 4'd0;
                        stg   <= stg + 2'd1;
                        state <= stg == 2'd3 ? LAST : ISSUE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                UNLOAD: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // write-back delay line: PE results land PE_LAT cycles after issue; abort drops anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PE_LAT; i++) pipe[i] <= 9'd0;
        end else if (abort) begin
            for (int i = 0; i < PE_LAT; i++) pipe[i] <= 9'd0;
        end else begin
            pipe[0] <= {pe_valid, rd_addr_a, rd_addr_b};
            for (int i = 1; i < PE_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl: directed and random checks of fft_seq_ctrl at PE_LAT 1 and 3 against a schedule-based model
module tb_fft_seq_ctrl;
    import fft_seq_pkg::*;

`ifdef FFT_SEQ_CTRL_UNLOAD_EN
    localparam int U = 16;
`else
    localparam int U = 0;
`endif

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic busy1, done1, pv1, we1, busy3, done3, pv3, we3;
    logic [1:0] stg1, stg3;
    logic [3:0] ra1, rb1, wa1, wb1, ra3, rb3, wa3, wb3;
    logic [2:0] pw1, pw3;
`ifdef FFT_SEQ_CTRL_UNLOAD_EN
    logic ov1, ov3;
    logic [3:0] ob1, ob3;
`endif

    always #5 clk = ~clk;

    fft_seq_ctrl #(.PE_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy1), .done(done1),
        .stage(stg1), .rd_addr_a(ra1), .rd_addr_b(rb1), .power(pw1), .pe_valid(pv1),
`ifdef FFT_SEQ_CTRL_UNLOAD_EN
        .out_valid(ov1), .out_bin(ob1),
`endif
        .wr_en(we1), .wr_addr_a(wa1), .wr_addr_b(wb1)
    );

    fft_seq_ctrl #(.PE_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy3), .done(done3),
        .stage(stg3), .rd_addr_a(ra3), .rd_addr_b(rb3), .power(pw3), .pe_valid(pv3),
`ifdef FFT_SEQ_CTRL_UNLOAD_EN
        .out_valid(ov3), .out_bin(ob3),
`endif
        .wr_en(we3), .wr_addr_a(wa3), .wr_addr_b(wb3)
    );

    // packed view: busy[24] done[23] stage[22:21] ra[20:17] rb[16:13] pw[12:10] pv[9] we[8] wa[7:4] wb[3:0]
    logic [24:0] o [2];
    assign o[0] = {busy1, done1, stg1, ra1, rb1, pw1, pv1, we1, wa1, wb1};
    assign o[1] = {busy3, done3, stg3, ra3, rb3, pw3, pv3, we3, wa3, wb3};

    int n_chk = 0, n_fail = 0, cyc = 0, ts;
    int lat [2] = '{1, 3};
    bit run [2];
    int t0 [2];
    bit hv [2][4096];
    logic [3:0] ha [2][4096];
    logic [3:0] hb [2][4096];
    bit ab_hist [4096];
    logic [24:0] snap [2][4096];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic st, input logic ab);
        @(negedge clk);
        start = st;
        abort = ab;
        #1;
        ab_hist[cyc] = ab;
        for (int d = 0; d < 2; d++) begin
            int p, r, s, q, k, span, a, b, pw, fin;
            bit e_busy, e_done, e_pv, e_we, chk_stg, was;
            int e_stg;
            p = 8 + lat[d];
            fin = 4 * p + U + 1;
            r = cyc - t0[d];
            e_busy = 0; e_done = 0; e_pv = 0; e_stg = 0; chk_stg = 1; a = 0; b = 0; pw = 0;
            was = run[d];
            snap[d][cyc] = o[d];
            if (was) begin
                if (r <= 4 * p) begin
                    e_busy = 1;
                    s = (r - 1) / p;
                    q = (r - 1) % p;
                    e_stg = s;
                    if (q < 8 && !ab) begin
                        e_pv = 1;
                        k = q;
                        span = 8 >> s;
                        a = 2 * span * (k / span) + k % span;
                        b = a + span;
                        pw = ((k % span) << s) % 8;
                    end
                end else begin
                    chk_stg = 0;
                    if (r < fin) e_busy = 1;
                    else e_done = 1;
                end
            end
            hv[d][cyc] = e_pv;
            ha[d][cyc] = 4'(a);
            hb[d][cyc] = 4'(b);
            e_we = 0;
            if (cyc >= lat[d]) begin
                e_we = hv[d][cyc-lat[d]];
                for (int x = cyc - lat[d]; x < cyc; x++) if (ab_hist[x]) e_we = 0;
            end
            chk($sformatf("busy%0d", lat[d]), o[d][24], e_busy);
            chk($sformatf("done%0d", lat[d]), o[d][23], e_done);
            chk($sformatf("pe_valid%0d", lat[d]), o[d][9], e_pv);
            chk($sformatf("wr_en%0d", lat[d]), o[d][8], e_we);
            if (chk_stg) chk($sformatf("stage%0d", lat[d]), o[d][22:21], e_stg);
            if (e_pv || !was) chk($sformatf("rd_pw%0d", lat[d]), o[d][20:10], {4'(a), 4'(b), 3'(pw)});
            if (e_we) chk($sformatf("wr_addr%0d", lat[d]), o[d][7:0], {ha[d][cyc-lat[d]], hb[d][cyc-lat[d]]});
            if (!was && st && !ab) begin
                run[d] = 1;
                t0[d] = cyc;
            end else if (was && (ab || r == fin)) begin
                run[d] = 0;
            end
        end
        cyc++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset1", o[0], 0);
        chk("reset3", o[1], 0);
        @(negedge clk);
        rst = 1'b0;

        ts = cyc;
        step(1, 0);
        repeat (69) step(0, 0);
        chk("s0k3", snap[0][ts+4][20:10], {4'd3, 4'd11, 3'd3});
        chk("s1k5", snap[0][ts+15][20:10], {4'd9, 4'd13, 3'd2});
        chk("s3k6", snap[0][ts+34][20:10], {4'd12, 4'd13, 3'd0});
        chk("done_at_lat1", snap[0][ts+37+U][23], 1);
        chk("busy_last_lat1", snap[0][ts+36+U][24:23], 2'b10);
        chk("done_at_lat3", snap[1][ts+45+U][23], 1);
        chk("first_wr_lat3", snap[1][ts+4][8:0], {1'b1, 4'd0, 4'd8});
        chk("no_early_wr_lat3", snap[1][ts+3][8], 0);

        ts = cyc;
        step(1, 0);
        repeat (11) step(0, 0);
        step(0, 1);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        repeat (55 + U) step(0, 0);
        chk("abort_idle", snap[0][ts+13][24:23], 0);
        chk("abort_no_wr1", snap[0][ts+13][8], 0);
        chk("abort_no_wr3", snap[1][ts+13][8], 0);
        chk("restart_done", snap[0][ts+52+U][23], 1);

        ts = cyc;
        repeat (2 * (37 + U) + 5) step(1, 0);
        repeat (60) step(0, 0);
        chk("held_done1", snap[0][ts+37+U][23], 1);
        chk("held_idle", snap[0][ts+38+U][24], 0);
        chk("held_rerun", snap[0][ts+39+U][24], 1);
        chk("held_done2", snap[0][ts+2*(37+U)+1][23], 1);

        step(1, 0);
        repeat (5) step(0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst1", o[0], 0);
        chk("async_rst3", o[1], 0);
        @(posedge clk);
        #1;
        chk("rst_hold1", o[0], 0);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            run[d] = 0;
            for (int x = 0; x < 4096; x++) hv[d][x] = 0;
        end
        repeat (15) step(0, 0);

        repeat (700) step($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
